// File: rtl/vec_offload_queue.sv
// Speculative vector-instruction queue between issue and an external vector unit.
// Entries are released only after commit; responses return to scalar writeback one cycle later.
module vec_offload_queue #(
    parameter  int XLEN            = 64,
    parameter  int DEPTH           = 4,
    parameter  int TRANS_ID_W      = 3,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_insn_i,
    input  logic [XLEN-1:0]       issue_rs1_i,
    input  logic [XLEN-1:0]       issue_rs2_i,
    input  logic [TRANS_ID_W-1:0] issue_trans_id_i,
    input  logic                  commit_i,
    input  logic [TRANS_ID_W-1:0] commit_trans_id_i,
    output logic                  vec_req_valid_o,
    input  logic                  vec_req_ready_i,
    output logic [31:0]           vec_req_insn_o,
    output logic [XLEN-1:0]       vec_req_rs1_o,
    output logic [XLEN-1:0]       vec_req_rs2_o,
    output logic [TRANS_ID_W-1:0] vec_req_trans_id_o,
    input  logic                  vec_resp_valid_i,
    input  logic [TRANS_ID_W-1:0] vec_resp_trans_id_i,
    input  logic [XLEN-1:0]       vec_resp_result_i,
    input  logic                  vec_resp_exception_i,
    output logic                  wb_valid_o,
    output logic [TRANS_ID_W-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]       wb_result_o,
    output logic                  wb_exception_o,
    output logic [OW-1:0]         outstanding_o,
    output logic                  busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

    logic [31:0]           r_insn [DEPTH];
    logic [XLEN-1:0]       r_rs1  [DEPTH];
    logic [XLEN-1:0]       r_rs2  [DEPTH];
    logic [TRANS_ID_W-1:0] r_id   [DEPTH];

    logic [PW-1:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic [PW-1:0] w_cmt_ptr_next;
    logic [OW-1:0] r_outstanding;

    logic                  r_wb_valid;
    logic [TRANS_ID_W-1:0] r_wb_trans_id;
    logic [XLEN-1:0]       r_wb_result;
    logic                  r_wb_exception;

    logic w_full, w_empty, w_push, w_commit, w_dispatch, w_resp;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign issue_ready_o   = !w_full && !flush_i;
    assign w_push          = issue_valid_i && issue_ready_o;
    assign w_commit        = commit_i && (r_cmt_ptr != r_wr_ptr);
    assign w_cmt_ptr_next  = r_cmt_ptr + PW'(w_commit);
    assign vec_req_valid_o = (r_rd_ptr != r_cmt_ptr) && (r_outstanding < MAX_OS);
    assign w_dispatch      = vec_req_valid_o && vec_req_ready_i;
    // A stray response with nothing in flight is dropped entirely, including its writeback.
    assign w_resp          = vec_resp_valid_i && (r_outstanding != '0);

    assign vec_req_insn_o     = r_insn[r_rd_ptr[AW-1:0]];
    assign vec_req_rs1_o      = r_rs1[r_rd_ptr[AW-1:0]];
    assign vec_req_rs2_o      = r_rs2[r_rd_ptr[AW-1:0]];
    assign vec_req_trans_id_o = r_id[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_insn[r_wr_ptr[AW-1:0]] <= issue_insn_i;
            r_rs1[r_wr_ptr[AW-1:0]]  <= issue_rs1_i;
            r_rs2[r_wr_ptr[AW-1:0]]  <= issue_rs2_i;
            r_id[r_wr_ptr[AW-1:0]]   <= issue_trans_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr      <= '0;
            r_cmt_ptr     <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            r_cmt_ptr <= w_cmt_ptr_next;
            // Flush rewinds to the post-commit pointer so a same-cycle commit survives.
            if (flush_i) begin
                r_wr_ptr <= w_cmt_ptr_next;
            end else if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_dispatch) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_dispatch, w_resp})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_valid     <= 1'b0;
            r_wb_trans_id  <= '0;
            r_wb_result    <= '0;
            r_wb_exception <= 1'b0;
        end else begin
            r_wb_valid <= w_resp;
            if (w_resp) begin
                r_wb_trans_id  <= vec_resp_trans_id_i;
                r_wb_result    <= vec_resp_result_i;
                r_wb_exception <= vec_resp_exception_i;
            end
        end
    end

    assign wb_valid_o     = r_wb_valid;
    assign wb_trans_id_o  = r_wb_trans_id;
    assign wb_result_o    = r_wb_result;
    assign wb_exception_o = r_wb_exception;
    assign outstanding_o  = r_outstanding;
    assign busy_o         = !w_empty || (r_outstanding != '0);

    a_commit_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_i |-> (r_cmt_ptr != r_wr_ptr) && (commit_trans_id_i == r_id[r_cmt_ptr[AW-1:0]]));

    a_resp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        vec_resp_valid_i |-> (r_outstanding != '0));

endmodule

// File: tb/tb_vec_offload_queue.sv
// Directed bench for vec_offload_queue: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_vec_offload_queue;

    localparam int XLEN = 64;
    localparam int DEPTH = 4;
    localparam int TIDW = 3;
    localparam int MAXO = 4;
    localparam int OW = $clog2(MAXO + 1);

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            issue_valid_i = 1'b0;
    logic            issue_ready_o;
    logic [31:0]     issue_insn_i = '0;
    logic [XLEN-1:0] issue_rs1_i = '0;
    logic [XLEN-1:0] issue_rs2_i = '0;
    logic [TIDW-1:0] issue_trans_id_i = '0;
    logic            commit_i = 1'b0;
    logic [TIDW-1:0] commit_trans_id_i = '0;
    logic            vec_req_valid_o;
    logic            vec_req_ready_i = 1'b0;
    logic [31:0]     vec_req_insn_o;
    logic [XLEN-1:0] vec_req_rs1_o;
    logic [XLEN-1:0] vec_req_rs2_o;
    logic [TIDW-1:0] vec_req_trans_id_o;
    logic            vec_resp_valid_i = 1'b0;
    logic [TIDW-1:0] vec_resp_trans_id_i = '0;
    logic [XLEN-1:0] vec_resp_result_i = '0;
    logic            vec_resp_exception_i = 1'b0;
    logic            wb_valid_o;
    logic [TIDW-1:0] wb_trans_id_o;
    logic [XLEN-1:0] wb_result_o;
    logic            wb_exception_o;
    logic [OW-1:0]   outstanding_o;
    logic            busy_o;

    vec_offload_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TRANS_ID_W(TIDW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_insn_i(issue_insn_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_trans_id_i(issue_trans_id_i),
        .commit_i(commit_i), .commit_trans_id_i(commit_trans_id_i),
        .vec_req_valid_o(vec_req_valid_o), .vec_req_ready_i(vec_req_ready_i),
        .vec_req_insn_o(vec_req_insn_o), .vec_req_rs1_o(vec_req_rs1_o),
        .vec_req_rs2_o(vec_req_rs2_o), .vec_req_trans_id_o(vec_req_trans_id_o),
        .vec_resp_valid_i(vec_resp_valid_i), .vec_resp_trans_id_i(vec_resp_trans_id_i),
        .vec_resp_result_i(vec_resp_result_i), .vec_resp_exception_i(vec_resp_exception_i),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
        .wb_exception_o(wb_exception_o), .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;
    int seq = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: uncommitted and committed-unsent entries as FIFOs, in-flight as a count.
    typedef struct {
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [TIDW-1:0] id;
    } entry_t;

    entry_t          m_unc[$];
    entry_t          m_cmt[$];
    int              m_os = 0;
    logic            m_wb_v = 1'b0;
    logic [TIDW-1:0] m_wb_id = '0;
    logic [XLEN-1:0] m_wb_res = '0;
    logic            m_wb_exc = 1'b0;

    function automatic bit f_ready();
        return ((m_unc.size() + m_cmt.size()) < DEPTH) && !flush_i;
    endfunction

    function automatic bit f_valid();
        return (m_cmt.size() > 0) && (m_os < MAXO);
    endfunction

    task automatic model_step();
        bit d, c, p, r;
        entry_t e;
        if (!rst_ni) begin
            m_unc.delete();
            m_cmt.delete();
            m_os = 0;
            m_wb_v = 1'b0;
            m_wb_id = '0;
            m_wb_res = '0;
            m_wb_exc = 1'b0;
            return;
        end
        d = f_valid() && vec_req_ready_i;
        c = commit_i && (m_unc.size() > 0);
        p = issue_valid_i && f_ready();
        r = vec_resp_valid_i && (m_os > 0);
        if (d) void'(m_cmt.pop_front());
        if (c) m_cmt.push_back(m_unc.pop_front());
        if (flush_i) m_unc.delete();
        if (p) begin
            e.insn = issue_insn_i;
            e.rs1 = issue_rs1_i;
            e.rs2 = issue_rs2_i;
            e.id = issue_trans_id_i;
            m_unc.push_back(e);
        end
        m_os = m_os + int'(d) - int'(r);
        m_wb_v = r;
        if (r) begin
            m_wb_id = vec_resp_trans_id_i;
            m_wb_res = vec_resp_result_i;
            m_wb_exc = vec_resp_exception_i;
        end
    endtask

    always @(posedge clk_i or negedge rst_ni) model_step();

    // Every-cycle comparison, half a period away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("issue_ready", issue_ready_o, f_ready());
            chk("req_valid", vec_req_valid_o, f_valid());
            chk("outstanding", outstanding_o, m_os);
            chk("busy", busy_o, (m_unc.size() + m_cmt.size() > 0) || (m_os > 0));
            chk("wb_valid", wb_valid_o, m_wb_v);
            chk("wb_trans_id", wb_trans_id_o, m_wb_id);
            chk("wb_result", wb_result_o, m_wb_res);
            chk("wb_exception", wb_exception_o, m_wb_exc);
            if (f_valid()) begin
                chk("req_trans_id", vec_req_trans_id_o, m_cmt[0].id);
                chk("req_insn", vec_req_insn_o, m_cmt[0].insn);
                chk("req_rs1", vec_req_rs1_o, m_cmt[0].rs1);
                chk("req_rs2", vec_req_rs2_o, m_cmt[0].rs2);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        commit_i = 1'b0;
        flush_i = 1'b0;
        vec_resp_valid_i = 1'b0;
    endtask

    task automatic set_push(input logic [TIDW-1:0] id);
        logic [15:0] s;
        s = 16'(seq);
        seq++;
        issue_valid_i = 1'b1;
        issue_trans_id_i = id;
        issue_insn_i = {16'h5700, s[7:0], 5'h0, id};
        issue_rs1_i = {16'hA5A5, s, 29'h0, id};
        issue_rs2_i = ~{16'hA5A5, s, 29'h0, id};
    endtask

    task automatic set_commit(input logic [TIDW-1:0] id);
        commit_i = 1'b1;
        commit_trans_id_i = id;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_cmt.size() == 0 && m_os == 0) begin
                done = 1'b1;
                break;
            end
            vec_req_ready_i = 1'b1;
            if (m_os > 0) begin
                vec_resp_valid_i = 1'b1;
                vec_resp_trans_id_i = 3'(i);
                vec_resp_result_i = {$urandom, $urandom};
                vec_resp_exception_i = 1'b0;
            end
            tick();
        end
        chk("drain_done", done, 1'b1);
        $display("drain complete: outstanding=%0d busy=%0d", outstanding_o, busy_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst_ni = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        #1;
        chk("rst_issue_ready", issue_ready_o, 1'b1);
        chk("rst_req_valid", vec_req_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        $display("reset released: ready=%0d busy=%0d", issue_ready_o, busy_o);

        // Speculative entries are held until committed
        vec_req_ready_i = 1'b0;
        set_push(3'd1); tick();
        set_push(3'd2); tick();
        set_push(3'd3); tick();
        tick();
        chk("t1_no_dispatch", vec_req_valid_o, 1'b0);
        set_commit(3'd1); tick();
        chk("t1_valid", vec_req_valid_o, 1'b1);
        chk("t1_id", vec_req_trans_id_o, 3'd1);
        chk("t1_rs1", vec_req_rs1_o, 64'hA5A5_0000_0000_0001);
        chk("t1_rs2", vec_req_rs2_o, 64'h5A5A_FFFF_FFFF_FFFE);
        $display("commit id1: req_valid=%0d id=%0d rs1=%h", vec_req_valid_o, vec_req_trans_id_o, vec_req_rs1_o);
        set_commit(3'd2); tick();
        set_commit(3'd3); tick();
        drain();

        // Full queue, slot release and pointer wrap
        vec_req_ready_i = 1'b0;
        set_push(3'd4); tick();
        set_push(3'd5); tick();
        set_push(3'd6); tick();
        set_push(3'd7); tick();
        chk("t2_full_ready", issue_ready_o, 1'b0);
        set_push(3'd0); tick();
        set_commit(3'd4); tick();
        vec_req_ready_i = 1'b1; tick();
        vec_req_ready_i = 1'b0;
        chk("t2_ready_after_dispatch", issue_ready_o, 1'b1);
        set_push(3'd0); tick();
        set_commit(3'd5); tick();
        set_commit(3'd6); tick();
        set_commit(3'd7); tick();
        set_commit(3'd0); tick();
        $display("wrap test: all committed, outstanding=%0d", outstanding_o);
        drain();

        // Flush together with a commit; refused push in the flush cycle
        vec_req_ready_i = 1'b0;
        set_push(3'd1); tick();
        set_push(3'd2); tick();
        set_push(3'd3); tick();
        set_commit(3'd1); tick();
        set_commit(3'd2);
        flush_i = 1'b1;
        set_push(3'd4);
        #1;
        chk("t3_flush_ready", issue_ready_o, 1'b0);
        tick();
        chk("t3_busy_after_flush", busy_o, 1'b1);
        $display("flush with commit id2: busy=%0d", busy_o);
        drain();
        chk("t3_busy_idle", busy_o, 1'b0);

        // Outstanding limit and writeback of a response
        vec_req_ready_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            set_push(3'(k));
            if (k > 1) set_commit(3'(k - 1));
            tick();
        end
        set_commit(3'd6); tick();
        repeat (3) tick();
        chk("t4_outstanding_max", outstanding_o, 4);
        chk("t4_valid_blocked", vec_req_valid_o, 1'b0);
        $display("limit: outstanding=%0d req_valid=%0d", outstanding_o, vec_req_valid_o);
        vec_resp_valid_i = 1'b1;
        vec_resp_trans_id_i = 3'd5;
        vec_resp_result_i = 64'hDEAD_BEEF;
        vec_resp_exception_i = 1'b1;
        tick();
        chk("t5_wb_valid", wb_valid_o, 1'b1);
        chk("t5_wb_id", wb_trans_id_o, 3'd5);
        chk("t5_wb_result", wb_result_o, 64'hDEAD_BEEF);
        chk("t5_wb_exc", wb_exception_o, 1'b1);
        $display("writeback: valid=%0d id=%0d result=%h exc=%0d", wb_valid_o, wb_trans_id_o, wb_result_o, wb_exception_o);
        tick();
        chk("t4_outstanding_refill", outstanding_o, 4);
        chk("t5_wb_pulse_end", wb_valid_o, 1'b0);
        chk("t5_wb_hold", wb_result_o, 64'hDEAD_BEEF);
        drain();

        // Asynchronous reset with traffic in flight
        vec_req_ready_i = 1'b1;
        set_push(3'd1); tick();
        set_push(3'd2); set_commit(3'd1); tick();
        set_commit(3'd2); tick();
        tick();
        vec_req_ready_i = 1'b0;
        set_push(3'd3); tick();
        set_push(3'd4); tick();
        chk("t6_pre_outstanding", outstanding_o, 2);
        rst_ni = 1'b0;
        vec_resp_valid_i = 1'b1;
        vec_resp_trans_id_i = 3'd2;
        vec_resp_result_i = 64'h1234;
        #1;
        chk("t6_rst_busy", busy_o, 1'b0);
        chk("t6_rst_outstanding", outstanding_o, 0);
        chk("t6_rst_valid", vec_req_valid_o, 1'b0);
        chk("t6_rst_wb", wb_valid_o, 1'b0);
        chk("t6_rst_ready", issue_ready_o, 1'b1);
        $display("async reset: busy=%0d outstanding=%0d", busy_o, outstanding_o);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("t6_no_wb_after", wb_valid_o, 1'b0);
        chk("t6_busy_after", busy_o, 1'b0);
        tick();
        chk("t6_no_wb_after2", wb_valid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_offload_queue.md
Name: vec_offload_queue

Overview:
- Sits between the issue stage and the external vector unit when RVV is enabled.
- Buffers vector instructions and their scalar operands while they are still speculative.
- Releases an instruction to the vector unit only after the scoreboard commits it.
- Tracks requests in flight to the vector unit and returns their results to scalar writeback, one cycle after each vector-unit response.

Parameters:
- XLEN, 64, scalar operand/result width
- DEPTH, 4, queue entries; power of two, >=2
- TRANS_ID_W, 3, scoreboard transaction-id width (log2 of 8 scoreboard entries)
- MAX_OUTSTANDING, 4, maximum requests accepted by the vector unit without a response; >=1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all uncommitted entries
- issue_valid_i  in  1  issue stage presents a vector instruction
- issue_ready_o  out  1  queue can accept
- issue_insn_i  in  32  instruction word
- issue_rs1_i  in  XLEN  scalar operand 1
- issue_rs2_i  in  XLEN  scalar operand 2
- issue_trans_id_i  in  TRANS_ID_W  scoreboard id
- commit_i  in  1  oldest uncommitted entry is committed
- commit_trans_id_i  in  TRANS_ID_W  id being committed
- vec_req_valid_o  out  1  request to vector unit
- vec_req_ready_i  in  1  vector unit accepts
- vec_req_insn_o  out  32  head instruction
- vec_req_rs1_o  out  XLEN  head operand 1
- vec_req_rs2_o  out  XLEN  head operand 2
- vec_req_trans_id_o  out  TRANS_ID_W  head id
- vec_resp_valid_i  in  1  vector unit response
- vec_resp_trans_id_i  in  TRANS_ID_W  response id
- vec_resp_result_i  in  XLEN  scalar result
- vec_resp_exception_i  in  1  instruction raised exception
- wb_valid_o  out  1  writeback pulse
- wb_trans_id_o  out  TRANS_ID_W  writeback id
- wb_result_o  out  XLEN  writeback data
- wb_exception_o  out  1  writeback exception flag
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  requests in flight
- busy_o  out  1  queue non-empty or outstanding_o != 0

Behaviour:
- Storage and pointers:
  - Circular buffer with three pointers, each $clog2(DEPTH)+1 bits with an MSB wrap bit: wr_ptr, cmt_ptr, rd_ptr.
  - Invariant: rd_ptr <= cmt_ptr <= wr_ptr in modular order.
  - Full when wr_ptr - rd_ptr == DEPTH.
  - Empty when wr_ptr == rd_ptr.
- Reset: all pointers 0, outstanding 0, wb_* 0, vec_req_valid_o 0, busy_o 0. issue_ready_o is 1 in the first cycle after reset.
- Push:
  - issue_ready_o = !full && !flush_i.
  - On issue_valid_i && issue_ready_o, the entry is written at wr_ptr and wr_ptr increments.
- Commit:
  - On commit_i, cmt_ptr increments.
  - Legal only when cmt_ptr != wr_ptr at the cycle start and commit_trans_id_i equals the id stored at cmt_ptr; otherwise an assertion fires.
  - An entry pushed in cycle N is committable from cycle N+1.
- Dispatch:
  - vec_req_valid_o = (rd_ptr != cmt_ptr) && (outstanding < MAX_OUTSTANDING).
  - vec_req_* payload comes from the entry at rd_ptr.
  - On handshake, rd_ptr increments and outstanding increments.
  - An entry committed in cycle N is first presented in cycle N+1.
  - Once vec_req_valid_o is asserted, the payload stays stable until handshake. A flush never withdraws it, because the entry is committed.
- Flush:
  - wr_ptr <= cmt_ptr (after that cycle's commit is applied), so a commit and a flush in the same cycle preserve the committed entry.
  - A push in a flush cycle is refused (ready low).
  - Committed-but-unsent entries and outstanding requests are unaffected.
- Response and writeback:
  - On vec_resp_valid_i, outstanding decrements.
  - Handshake and response in the same cycle leave outstanding unchanged.
  - A response while outstanding == 0 is ignored and triggers an assertion.
  - wb_valid_o pulses exactly one cycle after vec_resp_valid_i, with the registered id, result and exception.
  - wb_* hold their last value when wb_valid_o is 0.
- Simultaneous events: push, commit, dispatch and response can all occur in one cycle, and each pointer/counter updates independently.
- Reset mid-operation: all contents are dropped immediately (asynchronous) with no writeback.

Test Plan:
- Push ids 1,2,3 without commit -> vec_req_valid_o stays 0. Commit id 1 -> vec_req_valid_o=1 next cycle with trans_id 1 and rs1/rs2 intact.
- Fill 4 entries -> issue_ready_o=0. Commit+dispatch 1 entry -> issue_ready_o=1 the following cycle; 5th push accepted. Pointer wraps through 2*DEPTH pushes with correct order.
- Push 3, commit 1, flush in the same cycle as commit of the 2nd -> entries 1,2 dispatched, entry 3 never appears, issue_ready_o=0 during flush.
- vec_req_ready_i=1, no responses, 6 committed entries -> exactly 4 handshakes, outstanding_o=4, valid low. One response -> 5th dispatched, outstanding_o stays 4.
- Response id 5, result 0xDEAD_BEEF, exception 1 in cycle N -> wb_valid_o=1, wb_trans_id_o=5, wb_result_o=0xDEADBEEF, wb_exception_o=1 in cycle N+1 only.
- Assert rst_ni low with 2 outstanding and 2 queued -> all outputs at reset values immediately. busy_o=0, and no wb pulse after release.
